spi_monarch_16: RTL and testbench
=================================

SPI_MONARCH_16 -- requirements
Module: spi_monarch_16

Interface
REQ-001 SHALL have parameter: none; SCLK ratio fixed at clk/32.
REQ-002 SHALL have port: clk  input  1  system clock, 50 MHz.
REQ-003 SHALL have port: rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port: wrt  input  1  single-cycle pulse; starts a 16-bit transaction.
REQ-005 SHALL have port: wt_data  input  16  command/data to transmit, MSB first.
REQ-006 SHALL have port: done  output  1  registered; high when a transaction completes, held until the next accepted wrt.
REQ-007 SHALL have port: rd_data  output  16  word received on MISO, MSB first.
REQ-008 SHALL have port: SS_n  output  1  registered serf select, active-low.
REQ-009 SHALL have port: SCLK  output  1  serial clock, idles high.
REQ-010 SHALL have port: MOSI  output  1  serial data out.
REQ-011 SHALL have port: MISO  input  1  serial data in.

Function
REQ-012 SHALL use a 5-bit free-running divider sclk_div while busy; SCLK = sclk_div[4].
REQ-013 SHALL, on wrt in IDLE: load the 16-bit shift register with wt_data, load sclk_div=5'b10111, clear bit count, drive SS_n low, clear done, and enter FRNT_PRCH.
REQ-014 SHALL ignore wrt in FRNT_PRCH and SHIFTING; the transaction in flight is unaffected.
REQ-015 SHALL drive MOSI from shift-register bit 15 at all times.
REQ-016 SHALL sample MISO into a 1-bit register on the cycle where sclk_div==5'b01111, one clk before the SCLK rise.
REQ-017 SHALL, in FRNT_PRCH, move to SHIFTING at sclk_div==5'b11111 without shifting; this first SCLK fall is the front porch.
REQ-018 SHALL, in SHIFTING at sclk_div==5'b11111, shift left by one with the sampled MISO entering bit 0, and increment the 4-bit bit count.
REQ-019 SHALL, on the shift taken with bit count==15 (the 16th shift):
  - set done and SS_n high;
  - reload sclk_div=5'b10111 so SCLK stays high with no 17th fall;
  - return to IDLE.
REQ-020 SHALL hold sclk_div at 5'b10111 in IDLE (SCLK=1).
REQ-021 SHALL produce exactly 16 SCLK rising edges per transaction, with SCLK period 32 clk and 50% duty cycle.
REQ-022 SHALL assert done on the 521st clk edge after the edge that samples wrt.
REQ-023 SHALL present rd_data equal to the shift register, valid and stable while done=1.
REQ-024 SHALL accept a wrt arriving in the same cycle done is high; done clears on the next edge.

Reset
REQ-025 SHALL, on rst_n low at any time including mid-transaction, immediately force:
  - state=IDLE, SS_n=1, done=0;
  - sclk_div=5'b10111 (SCLK=1);
  - shift register=16'h0000, bit count=0.

Structure
REQ-026 SHALL declare the 3-state enum (IDLE, FRNT_PRCH, SHIFTING) locally; no shared package is required.
REQ-027 SHALL define divider load (5'b10111), sample point (5'b01111) and shift point (5'b11111) as local constants.
REQ-028 SHALL be a single module with no sub-modules; it is instantiated by the inertial interface and by the team's other SPI-attached blocks.

Verification
REQ-029 SHALL cover loopback (MISO tied to MOSI), wt_data=16'hA5C3 -> rd_data=16'hA5C3, done high exactly 521 clks after wrt, and exactly 16 SCLK rises counted.
REQ-030 SHALL cover a serf model returning 16'h8001 to command 16'h0D02 -> MOSI bits observed on SCLK rises = 0x0D02, rd_data=16'h8001.
REQ-031 SHALL cover wrt re-pulsed at clk 100 of a transaction -> no restart, done still at clk 521, rd_data unchanged by the second wrt.
REQ-032 SHALL cover rst_n low at clk 300 -> SS_n=1, SCLK=1, done=0 within the same cycle; a following wrt yields a correct transaction.
REQ-033 SHALL cover wrt issued in the cycle done rises -> done low next clk, second transaction completes, SS_n high for exactly one clk between transactions.
REQ-034 SHALL cover idle check: with no wrt for 2000 clks -> SCLK=1, SS_n=1, MOSI stable, done unchanged.

Source files
------------

// File: rtl/spi_monarch_16.sv
// SPI monarch: one 16-bit full-duplex transaction per wrt pulse, SCLK = clk/32, SCLK idles high.
// Serf select and done are registered; rd_data is the shift register itself.
module spi_monarch_16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wrt,
  input  logic [15:0] wt_data,
  output logic        done,
  output logic [15:0] rd_data,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);

  typedef enum logic [1:0] {
    IDLE,
    FRNT_PRCH,
    SHIFTING
  } state_t;

  localparam logic [4:0] DIV_LOAD = 5'b10111;
  localparam logic [4:0] SMPL_PT  = 5'b01111;
  localparam logic [4:0] SHFT_PT  = 5'b11111;

  state_t      r_state;
  state_t      w_nxtState;
  logic [4:0]  r_sclkDiv;
  logic [15:0] r_shftReg;
  logic [3:0]  r_bitCnt;
  logic        r_misoSmpl;
  logic        r_done;
  logic        r_ssN;
  logic        w_load;
  logic        w_shift;
  logic        w_finish;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nxtState;
  end

  always_comb begin
    w_nxtState = r_state;
    w_load     = 1'b0;
    w_shift    = 1'b0;
    w_finish   = 1'b0;
    case (r_state)
      IDLE: begin
        if (wrt) begin
          w_load     = 1'b1;
          w_nxtState = FRNT_PRCH;
        end
      end
      FRNT_PRCH: begin
        if (r_sclkDiv == SHFT_PT) w_nxtState = SHIFTING;
      end
      SHIFTING: begin
        if (r_sclkDiv == SHFT_PT) begin
          w_shift = 1'b1;
          if (r_bitCnt == 4'hF) begin
            w_finish   = 1'b1;
            w_nxtState = IDLE;
          end
        end
      end
      default: w_nxtState = IDLE;
    endcase
  end

  // Reloading on the final shift parks SCLK high so there is no 17th falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_sclkDiv <= DIV_LOAD;
    else if (w_load || w_finish) r_sclkDiv <= DIV_LOAD;
    else if (r_state != IDLE)    r_sclkDiv <= r_sclkDiv + 5'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                         r_misoSmpl <= 1'b0;
    else if (r_state != IDLE && r_sclkDiv == SMPL_PT)   r_misoSmpl <= MISO;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shftReg <= 16'h0000;
      r_bitCnt  <= 4'h0;
    end else if (w_load) begin
      r_shftReg <= wt_data;
      r_bitCnt  <= 4'h0;
    end else if (w_shift) begin
      r_shftReg <= {r_shftReg[14:0], r_misoSmpl};
      r_bitCnt  <= r_bitCnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done <= 1'b0;
      r_ssN  <= 1'b1;
    end else if (w_load) begin
      r_done <= 1'b0;
      r_ssN  <= 1'b0;
    end else if (w_finish) begin
      r_done <= 1'b1;
      r_ssN  <= 1'b1;
    end
  end

  assign done    = r_done;
  assign SS_n    = r_ssN;
  assign SCLK    = r_sclkDiv[4];
  assign MOSI    = r_shftReg[15];
  assign rd_data = r_shftReg;

endmodule

// File: tb/tb_spi_monarch_16.sv
// Bench for spi_monarch_16: scoreboard of expected transactions, serf model or loopback on MISO.
// Timing, SCLK edge count, MOSI content, reset abort, ignored wrt, back-to-back and idle behaviour.
module tb_spi_monarch_16;

  logic        clk;
  logic        rst_n;
  logic        wrt;
  logic [15:0] wt_data;
  logic        done;
  logic [15:0] rd_data;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;

  typedef struct {
    logic [15:0] expRd;
    logic [15:0] expMosi;
    int          startEdge;
  } exp_t;

  exp_t        expQ[$];
  int          checkCnt = 0;
  int          passCnt  = 0;
  int          cycleCnt = 0;
  int          sclkRises;
  int          firstRise;
  int          lastRise;
  logic [15:0] mosiCap;
  logic [15:0] serfReply;
  logic [15:0] serfShreg;
  logic        serfFirst;
  logic        loopback;

  spi_monarch_16 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wrt     (wrt),
    .wt_data (wt_data),
    .done    (done),
    .rd_data (rd_data),
    .SS_n    (SS_n),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .MISO    (MISO)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Serf drives MSB first, shifts on SCLK falls, and ignores the front-porch fall.
  always @(negedge SS_n) begin
    serfShreg = serfReply;
    serfFirst = 1'b1;
  end

  always @(negedge SCLK) begin
    if (!SS_n) begin
      if (serfFirst) serfFirst = 1'b0;
      else           serfShreg = {serfShreg[14:0], 1'b0};
    end
  end

  assign MISO = loopback ? MOSI : serfShreg[15];

  always @(posedge SCLK) begin
    if (!SS_n) begin
      if (sclkRises == 0) firstRise = cycleCnt;
      lastRise  = cycleCnt;
      mosiCap   = {mosiCap[14:0], MOSI};
      sclkRises = sclkRises + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCnt++;
    if (obs === exp) passCnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cycleCnt);
  endtask

  // Called at a negedge; wrt is sampled by the following posedge.
  task automatic applyStimulus(input logic [15:0] data, input logic [15:0] reply, input logic lb);
    exp_t e;
    wrt       = 1'b1;
    wt_data   = data;
    serfReply = reply;
    loopback  = lb;
    sclkRises = 0;
    mosiCap   = 16'h0000;
    e.expRd     = lb ? data : reply;
    e.expMosi   = data;
    e.startEdge = cycleCnt + 1;
    expQ.push_back(e);
    @(negedge clk);
    wrt = 1'b0;
  endtask

  task automatic waitDone();
    exp_t e;
    for (int i = 0; i < 700; i++) begin
      if (done) break;
      @(negedge clk);
    end
    if (expQ.size() == 0) begin
      checkOutput("scoreboardEmpty", 32'd0, 32'd1);
      return;
    end
    e = expQ.pop_front();
    if (!done) begin
      checkOutput("doneTimeout", 32'(done), 32'd1);
      return;
    end
    checkOutput("doneLatency", 32'(cycleCnt - e.startEdge), 32'd521);
    checkOutput("rdData", 32'(rd_data), 32'(e.expRd));
    checkOutput("mosiBits", 32'(mosiCap), 32'(e.expMosi));
    checkOutput("sclkRises", 32'(sclkRises), 32'd16);
    checkOutput("sclkSpan", 32'(lastRise - firstRise), 32'd480);
    checkOutput("ssnAtDone", 32'(SS_n), 32'd1);
    checkOutput("sclkAtDone", 32'(SCLK), 32'd1);
  endtask

  task automatic waitUntilEdge(input int target);
    for (int i = 0; i < 1000; i++) begin
      if (cycleCnt >= target) break;
      @(negedge clk);
    end
  endtask

  initial begin
    int   start;
    int   idleBad;
    logic idleMosi;
    logic idleDone;
    logic [15:0] rndA;
    logic [15:0] rndB;

    rst_n     = 1'b1;
    wrt       = 1'b0;
    wt_data   = 16'h0000;
    serfReply = 16'h0000;
    serfShreg = 16'h0000;
    serfFirst = 1'b0;
    loopback  = 1'b0;
    sclkRises = 0;
    firstRise = 0;
    lastRise  = 0;
    mosiCap   = 16'h0000;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rstSsn", 32'(SS_n), 32'd1);
    checkOutput("rstSclk", 32'(SCLK), 32'd1);
    checkOutput("rstDone", 32'(done), 32'd0);
    checkOutput("rstRd", 32'(rd_data), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] loopback A5C3");
    applyStimulus(16'hA5C3, 16'h0000, 1'b1);
    checkOutput("ssnLowAfterWrt", 32'(SS_n), 32'd0);
    waitDone();
    repeat (3) @(negedge clk);

    $display("[TB] serf reply 8001 to command 0D02");
    applyStimulus(16'h0D02, 16'h8001, 1'b0);
    waitDone();
    repeat (2) @(negedge clk);

    $display("[TB] wrt re-pulsed mid-transaction");
    applyStimulus(16'h3C5A, 16'h1234, 1'b0);
    start = cycleCnt - 1;
    waitUntilEdge(start + 100);
    wrt     = 1'b1;
    wt_data = 16'hFFFF;
    @(negedge clk);
    wrt     = 1'b0;
    waitDone();
    repeat (2) @(negedge clk);

    $display("[TB] reset mid-transaction");
    applyStimulus(16'h5555, 16'hAAAA, 1'b0);
    start = cycleCnt - 1;
    waitUntilEdge(start + 300);
    checkOutput("ssnBeforeAbort", 32'(SS_n), 32'd0);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("abortSsn", 32'(SS_n), 32'd1);
    checkOutput("abortSclk", 32'(SCLK), 32'd1);
    checkOutput("abortDone", 32'(done), 32'd0);
    checkOutput("abortRd", 32'(rd_data), 32'd0);
    void'(expQ.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    applyStimulus(16'hC3A5, 16'h7E81, 1'b0);
    waitDone();

    $display("[TB] wrt in the cycle done rises");
    rndA = 16'($urandom);
    rndB = 16'($urandom);
    applyStimulus(rndA, 16'h0F0F, 1'b0);
    waitDone();
    applyStimulus(rndB, 16'hF00F, 1'b0);
    checkOutput("doneClearedB2B", 32'(done), 32'd0);
    checkOutput("ssnLowB2B", 32'(SS_n), 32'd0);
    waitDone();

    $display("[TB] idle for 2000 clocks");
    idleBad  = 0;
    idleMosi = MOSI;
    idleDone = done;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (SCLK !== 1'b1 || SS_n !== 1'b1 || MOSI !== idleMosi || done !== idleDone)
        idleBad++;
    end
    checkOutput("idleViolations", 32'(idleBad), 32'd0);
    checkOutput("idleDoneHeld", 32'(done), 32'd1);

    $display("[TB] %0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
